// File: rtl/accum_stg_flush.sv
// Accumulation stage: merges consecutive same-row records into one running sum,
// emits completed rows into a small fall-through FIFO and flushes on end-of-stream.
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 8
`endif
`ifndef DATA_PRECISION
`define DATA_PRECISION 16
`endif
`ifndef BITS_ADDER_OUT_Q
`define BITS_ADDER_OUT_Q 2
`endif

module accum_stg_flush #(
  parameter int unsigned BITS_ROW_IDX   = `BITS_ROW_IDX,
  parameter int unsigned DATA_PRECISION = `DATA_PRECISION,
  parameter int unsigned DATA_WIDTH     = BITS_ROW_IDX + DATA_PRECISION + 1,
  parameter int unsigned BITS_OUT_Q     = `BITS_ADDER_OUT_Q,
  parameter int unsigned BITS_CNT       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] di,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  data_ended,
  input  logic                  next_stg_rd_en,
  output logic                  out_q_rd_ready,
  output logic [DATA_WIDTH-1:0] do_accum_stg_out_q,
  output logic                  done,
  output logic [BITS_CNT-1:0]   rec_cnt,
  output logic                  row_order_err
);

  localparam int unsigned DEPTH  = 32'd1 << BITS_OUT_Q;
  localparam int unsigned QCNT_W = BITS_OUT_Q + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                state, state_nx;
  logic [DATA_WIDTH-1:0]     acc, acc_nx;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];
  logic [BITS_OUT_Q-1:0]     wr_ptr, rd_ptr, rd_ptr_nx;
  logic [QCNT_W-1:0]         q_cnt, q_cnt_nx;
  logic [DATA_WIDTH-1:0]     head_nx;
  logic                      push, pop, full, err_set, clr, accept;

  logic [BITS_ROW_IDX-1:0]   di_row, acc_row;
  logic [DATA_PRECISION-1:0] di_val, acc_val;
  logic                      di_vld;

  assign di_row  = di[DATA_WIDTH-1 -: BITS_ROW_IDX];
  assign di_val  = di[DATA_PRECISION:1];
  assign di_vld  = di[0];
  assign acc_row = acc[DATA_WIDTH-1 -: BITS_ROW_IDX];
  assign acc_val = acc[DATA_PRECISION:1];

  assign accept = in_valid && in_ready;
  assign full   = (q_cnt == QCNT_W'(DEPTH));
  assign pop    = next_stg_rd_en && (q_cnt != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, accumulator update and FIFO push decision
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    push     = 1'b0;
    err_set  = 1'b0;
    clr      = 1'b0;
    case (state)
      S_IDLE, S_ACCUM: begin
        if (accept && di_vld) begin
          if (state == S_IDLE) begin
            acc_nx   = di;
            state_nx = S_ACCUM;
          end else if (di_row == acc_row) begin
            acc_nx = {acc_row, acc_val + di_val, 1'b1};
          end else begin
            push    = 1'b1;
            acc_nx  = di;
            err_set = (di_row < acc_row);
          end
        end
        if (data_ended) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        if (!acc[0]) begin
          state_nx = S_DONE;
        end else if (!full) begin
          push     = 1'b1;
          acc_nx   = '0;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nx = S_IDLE;
          clr      = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; the next head is precomputed so the output stays registered
  always_comb begin
    q_cnt_nx  = q_cnt + QCNT_W'(push) - QCNT_W'(pop);
    rd_ptr_nx = rd_ptr + BITS_OUT_Q'(pop);
    if (q_cnt_nx == '0)                  head_nx = '0;
    else if (push && wr_ptr == rd_ptr_nx) head_nx = acc;
    else                                 head_nx = mem[rd_ptr_nx];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc                <= '0;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      q_cnt              <= '0;
      in_ready           <= 1'b1;
      out_q_rd_ready     <= 1'b0;
      do_accum_stg_out_q <= '0;
      done               <= 1'b0;
      rec_cnt            <= '0;
      row_order_err      <= 1'b0;
    end else begin
      acc                <= acc_nx;
      wr_ptr             <= wr_ptr + BITS_OUT_Q'(push);
      rd_ptr             <= rd_ptr_nx;
      q_cnt              <= q_cnt_nx;
      in_ready           <= ((state_nx == S_IDLE) || (state_nx == S_ACCUM)) &&
                            (q_cnt_nx != QCNT_W'(DEPTH));
      out_q_rd_ready     <= (q_cnt_nx != '0);
      do_accum_stg_out_q <= head_nx;
      done               <= (state_nx == S_DONE);
      if (clr)                         rec_cnt <= '0;
      else if (push && rec_cnt != '1)  rec_cnt <= rec_cnt + BITS_CNT'(1);
      if (clr)          row_order_err <= 1'b0;
      else if (err_set) row_order_err <= 1'b1;
    end
  end

endmodule
